axi_rd_arb: RTL

AXI_RD_ARB -- requirements
Module: axi_rd_arb

---
 rtl/axi_rd_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arb.sv
// axi_rd_arb
//   Arbitrates three cache-side read requesters onto a single AXI3 read
//   channel with one transaction in flight at a time. Fixed priority:
//   dcache refill > uncached read > icache refill.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   ird_req/ird_addr                 icache refill request (16-word line)
//   i_reload/icacheline_new          refill-done pulse and line
//   drd_req/drd_addr                 dcache refill request (8-word line)
//   d_reload/dcacheline_new          refill-done pulse and line
//   unrd_req/unrd_addr               uncached single-word read request
//   un_reload/unrd_data              read-done pulse and word
//   arid..arvalid/arready            AXI3 read-address channel
//   rid/rdata/rlast/rvalid/rready    AXI3 read-data channel
module axi_rd_arb #(
    parameter logic [3:0] ID_I  = 4'd0,
    parameter logic [3:0] ID_D  = 4'd1,
    parameter logic [3:0] ID_UN = 4'd2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ird_req,
    input  logic [31:0]  ird_addr,
    output logic         i_reload,
    output logic [511:0] icacheline_new,
    input  logic         drd_req,
    input  logic [31:0]  drd_addr,
    output logic         d_reload,
    output logic [255:0] dcacheline_new,
    input  logic         unrd_req,
    input  logic [31:0]  unrd_addr,
    output logic         un_reload,
    output logic [31:0]  unrd_data,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [3:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
    typedef enum logic [1:0] {SRC_I, SRC_D, SRC_UN} src_t;

    state_t         state_q;
    src_t           src_q, src_d;
    logic [31:0]    araddr_q, araddr_d;
    logic [3:0]     arlen_q, arlen_d;
    logic [3:0]     arid_q, arid_d;
    logic           arvalid_q, rready_q;
    logic           i_reload_q, d_reload_q, un_reload_q;
    logic [3:0]     beat_q, beat_d;
    logic [511:0]   iline_q;
    logic [255:0]   dline_q;
    logic [31:0]    undata_q;
    logic           any_req;

    // Sub-line address bits and rid are intentionally ignored.
    logic           unused_bits;
    assign unused_bits = ^{rid, ird_addr[5:0], drd_addr[4:0]};

    // Grant selection and beat-counter increment (saturating at 15).
    always_comb begin
        any_req  = drd_req | unrd_req | ird_req;
        src_d    = SRC_I;
        araddr_d = {ird_addr[31:6], 6'b0};
        arlen_d  = 4'd15;
        arid_d   = ID_I;
        if (drd_req) begin
            src_d    = SRC_D;
            araddr_d = {drd_addr[31:5], 5'b0};
            arlen_d  = 4'd7;
            arid_d   = ID_D;
        end else if (unrd_req) begin
            src_d    = SRC_UN;
            araddr_d = unrd_addr;
            arlen_d  = 4'd0;
            arid_d   = ID_UN;
        end
        beat_d = (beat_q == 4'hF) ? beat_q : beat_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= SRC_I;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arid_q      <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            i_reload_q  <= 1'b0;
            d_reload_q  <= 1'b0;
            un_reload_q <= 1'b0;
            beat_q      <= '0;
            iline_q     <= '0;
            dline_q     <= '0;
            undata_q    <= '0;
        end else begin
            i_reload_q  <= 1'b0;
            d_reload_q  <= 1'b0;
            un_reload_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        src_q     <= src_d;
                        araddr_q  <= araddr_d;
                        arlen_q   <= arlen_d;
                        arid_q    <= arid_d;
                        beat_q    <= '0;
                        arvalid_q <= 1'b1;
                        state_q   <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        // Beats past the line size are dropped.
                        case (src_q)
                            SRC_I:  iline_q[{beat_q, 5'b0} +: 32] <= rdata;
                            SRC_D:  if (!beat_q[3])
                                        dline_q[{beat_q[2:0], 5'b0} +: 32] <= rdata;
                            SRC_UN: if (beat_q == 4'd0)
                                        undata_q <= rdata;
                            default: ;
                        endcase
                        beat_q <= beat_d;
                        if (rlast) begin
                            rready_q <= 1'b0;
                            state_q  <= DONE;
                            // Pulse is registered here so it is high during DONE.
                            case (src_q)
                                SRC_I:   i_reload_q  <= 1'b1;
                                SRC_D:   d_reload_q  <= 1'b1;
                                default: un_reload_q <= 1'b1;
                            endcase
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arid           = arid_q;
    assign araddr         = araddr_q;
    assign arlen          = arlen_q;
    assign arsize         = 3'b010;
    assign arburst        = 2'b01;
    assign arvalid        = arvalid_q;
    assign rready         = rready_q;
    assign i_reload       = i_reload_q;
    assign d_reload       = d_reload_q;
    assign un_reload      = un_reload_q;
    assign icacheline_new = iline_q;
    assign dcacheline_new = dline_q;
    assign unrd_data      = undata_q;

endmodule
